// File: rtl/rob_multi.sv
// rob_multi: in-order-retire reorder buffer with multi-wide dispatch, writeback and retire.
// Define ROB_RESULT_HI_EN to add a second 32-bit result word (wb_data_hi/ret_data_hi) per entry.
module rob_multi #(
    parameter int DEPTH = 16,
    parameter int DISP  = 4,
    parameter int RET   = 4,
    parameter int WB    = 4,
    parameter int RD    = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [$clog2(DISP+1)-1:0] disp_count,
    input  logic [4:0]                disp_dest_reg   [DISP],
    input  logic                      disp_dest_valid [DISP],
    output logic                      disp_ready,
    output logic [$clog2(DEPTH)-1:0]  disp_slot       [DISP],
    input  logic                      wb_valid        [WB],
    input  logic [$clog2(DEPTH)-1:0]  wb_slot         [WB],
    input  logic [31:0]               wb_data         [WB],
    input  logic                      wb_exc          [WB],
`ifdef ROB_RESULT_HI_EN
    input  logic [31:0]               wb_data_hi      [WB],
    output logic [31:0]               ret_data_hi     [RET],
`endif
    input  logic [$clog2(DEPTH)-1:0]  rd_idx          [RD],
    output logic [31:0]               rd_data         [RD],
    input  logic                      ret_ready,
    output logic                      ret_valid       [RET],
    output logic [4:0]                ret_dest_reg    [RET],
    output logic                      ret_dest_valid  [RET],
    output logic [31:0]               ret_data        [RET],
    output logic                      ret_exc         [RET],
    output logic [$clog2(RET+1)-1:0]  ret_count,
    input  logic                      flush,
    input  logic [$clog2(DEPTH)-1:0]  flush_idx,
    output logic [$clog2(DEPTH):0]    used_count,
    output logic                      empty,
    output logic                      full
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(RET + 1);

    logic [PW-1:0]    head, tail, head_n, tail_n;
    logic [PW-1:0]    used, free_count;
    logic [DEPTH-1:0] occupied, complete, exc, dest_valid;
    logic [DEPTH-1:0] occupied_n, complete_n, exc_n, dest_valid_n;
    logic [DEPTH-1:0] younger;
    logic [4:0]       dest_reg   [DEPTH];
    logic [4:0]       dest_reg_n [DEPTH];
    logic [31:0]      data       [DEPTH];
    logic [31:0]      data_n     [DEPTH];
`ifdef ROB_RESULT_HI_EN
    logic [31:0]      data_hi    [DEPTH];
    logic [31:0]      data_hi_n  [DEPTH];
`endif
    logic [IW-1:0]    ret_slot   [RET];
    logic [IW-1:0]    flush_age;
    logic [PW-1:0]    flush_len;
    logic             chain;

    assign used       = tail - head;
    assign free_count = PW'(DEPTH) - used;
    assign used_count = used;
    assign empty      = (head == tail);
    assign full       = (used == PW'(DEPTH));
    assign disp_ready = (free_count >= PW'(DISP));
    assign flush_age  = flush_idx - head[IW-1:0];
    assign flush_len  = {1'b0, flush_age} + PW'(1);

    // Age of a slot is its distance from head; anything older than flush_idx survives a flush.
    for (genvar s = 0; s < DEPTH; s++) begin : g_age
        assign younger[s] = (IW'(s) - head[IW-1:0]) > flush_age;
    end
    for (genvar i = 0; i < DISP; i++) begin : g_disp
        assign disp_slot[i] = tail[IW-1:0] + IW'(i);
    end
    for (genvar i = 0; i < RET; i++) begin : g_ret
        assign ret_slot[i] = head[IW-1:0] + IW'(i);
    end
    for (genvar i = 0; i < RD; i++) begin : g_rd
        assign rd_data[i] = data[rd_idx[i]];
    end

    // Retire group: contiguous completed entries from head, closed by the first exception.
    always_comb begin
        ret_count = '0;
        chain     = 1'b1;
        for (int i = 0; i < RET; i++) begin
            chain             = chain && occupied[ret_slot[i]] && complete[ret_slot[i]];
            ret_valid[i]      = chain;
            ret_exc[i]        = chain && exc[ret_slot[i]];
            ret_dest_reg[i]   = dest_reg[ret_slot[i]];
            ret_dest_valid[i] = dest_valid[ret_slot[i]];
            ret_data[i]       = data[ret_slot[i]];
`ifdef ROB_RESULT_HI_EN
            ret_data_hi[i]    = data_hi[ret_slot[i]];
`endif
            if (chain) begin
                ret_count = ret_count + CW'(1);
            end
            chain = chain && !exc[ret_slot[i]];
        end
    end

    always_comb begin
        head_n       = head;
        tail_n       = tail;
        occupied_n   = occupied;
        complete_n   = complete;
        exc_n        = exc;
        dest_reg_n   = dest_reg;
        dest_valid_n = dest_valid;
        data_n       = data;
`ifdef ROB_RESULT_HI_EN
        data_hi_n    = data_hi;
`endif
        // Later ports overwrite earlier ones, so the highest-numbered port wins a shared slot.
        for (int w = 0; w < WB; w++) begin
            if (wb_valid[w] && occupied[wb_slot[w]] && !(flush && younger[wb_slot[w]])) begin
                data_n[wb_slot[w]]     = wb_data[w];
`ifdef ROB_RESULT_HI_EN
                data_hi_n[wb_slot[w]]  = wb_data_hi[w];
`endif
                complete_n[wb_slot[w]] = 1'b1;
                exc_n[wb_slot[w]]      = exc[wb_slot[w]] | wb_exc[w];
            end
        end
        if (ret_ready) begin
            for (int i = 0; i < RET; i++) begin
                if (ret_valid[i]) begin
                    occupied_n[ret_slot[i]] = 1'b0;
                    complete_n[ret_slot[i]] = 1'b0;
                    exc_n[ret_slot[i]]      = 1'b0;
                end
            end
            head_n = head + PW'(ret_count);
        end
        // A flush point inside the retiring group simply leaves the buffer empty.
        if (flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (younger[s]) begin
                    occupied_n[s] = 1'b0;
                    complete_n[s] = 1'b0;
                    exc_n[s]      = 1'b0;
                end
            end
            if (ret_ready && (flush_len < PW'(ret_count))) begin
                tail_n = head_n;
            end else begin
                tail_n = head + flush_len;
            end
        end else if (disp_ready && (disp_count != '0)) begin
            for (int i = 0; i < DISP; i++) begin
                if (i < int'(disp_count)) begin
                    occupied_n[disp_slot[i]]   = 1'b1;
                    complete_n[disp_slot[i]]   = 1'b0;
                    exc_n[disp_slot[i]]        = 1'b0;
                    dest_reg_n[disp_slot[i]]   = disp_dest_reg[i];
                    dest_valid_n[disp_slot[i]] = disp_dest_valid[i];
                end
            end
            tail_n = tail + PW'(disp_count);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            occupied   <= '0;
            complete   <= '0;
            exc        <= '0;
            dest_valid <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dest_reg[s] <= '0;
                data[s]     <= '0;
`ifdef ROB_RESULT_HI_EN
                data_hi[s]  <= '0;
`endif
            end
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            occupied   <= occupied_n;
            complete   <= complete_n;
            exc        <= exc_n;
            dest_valid <= dest_valid_n;
            dest_reg   <= dest_reg_n;
            data       <= data_n;
`ifdef ROB_RESULT_HI_EN
            data_hi    <= data_hi_n;
`endif
        end
    end

endmodule
